subsurf_seq: RTL and testbench
==============================

// Module: subsurf_seq
// PURPOSE
// - Parametrised successor to the fixed 3-stage subsurf top-level sequencer: launches NUM_STAGES engines in order,
//   waits on each busy, repeats the whole chain ITER times (multi-level subdivision) and muxes the active
//   stage's RAM port bundle onto NUM_RAMS shared SRAM macros.
// - Sits between the engines (subdiv/neighbor/averager/...) and the RAM macros; host sees start/busy/done only.
// PARAMETERS
// - NUM_STAGES      3     engines run in index order 0..NUM_STAGES-1 (>=1)
// - NUM_RAMS        3     shared RAM ports muxed (>=1)
// - ADDR_WIDTH      11    RAM word address width
// - START_HOLD      3     cycles stage_start is held high per launch (>=1)
// - ITER_WIDTH      4     width of iteration count
// - TIMEOUT_CYCLES  65536 watchdog limit per stage (used only with SUBSURF_SEQ_TIMEOUT_EN)
// PORTS
// - clk          in   1                      clock, all logic on posedge
// - rst          in   1                      synchronous active-high reset
// - start        in   1                      begin run; sampled only in IDLE
// - iterations   in   ITER_WIDTH             chain repeats; latched on start; 0 treated as 1
// - abort        in   1                      cancel run
// - stage_start  out  NUM_STAGES             one-hot launch strobe to engines
// - stage_busy   in   NUM_STAGES             engine busy flags
// - st_en        in   NUM_STAGES*NUM_RAMS                 per-stage RAM enables, stage s ram r at [s*NUM_RAMS+r]
// - st_a         in   NUM_STAGES*NUM_RAMS*ADDR_WIDTH      per-stage addresses, same packing
// - st_we        in   NUM_STAGES*NUM_RAMS*4               per-stage byte write enables
// - st_di        in   NUM_STAGES*NUM_RAMS*32              per-stage write data
// - ram_en/ram_a/ram_we/ram_di  out  NUM_RAMS*{1,ADDR_WIDTH,4,32}  shared RAM port bundles
// - busy         out  1        high from cycle after accepted start until return to IDLE
// - done         out  1        1-cycle pulse on normal completion
// - aborted      out  1        1-cycle pulse when abort (or timeout) ends a run
// - cur_stage    out  $clog2(NUM_STAGES) (min 1)  active stage index
// - cur_iter     out  ITER_WIDTH             completed chain passes in current run
// BEHAVIOUR
// - Reset: state IDLE; busy, done, aborted, stage_start=0; cur_stage=0; cur_iter=0; iter limit reg=0.
// - States: IDLE -> LAUNCH -> WAIT -> (LAUNCH next stage | LAUNCH stage 0 next pass | FINISH) ; FINISH -> IDLE.
// - IDLE: start=1 -> latch iterations (0->1), cur_stage=0, cur_iter=0, busy=1, go LAUNCH.
// - LAUNCH: stage_start[cur_stage]=1 for exactly START_HOLD cycles, then WAIT. Engine busy ignored during LAUNCH.
// - WAIT: stage_busy[cur_stage]==0 -> if cur_stage<NUM_STAGES-1: cur_stage+1, LAUNCH;
//   else cur_iter+1; if cur_iter+1 < limit: cur_stage=0, LAUNCH; else FINISH.
// - FINISH: done=1 one cycle, busy=0 same cycle's next edge, cur_stage/cur_iter hold final values until next start.
// - Stage-to-stage gap: 1 cycle between busy low seen and next stage_start high.
// - RAM mux: combinational from registered cur_stage; in LAUNCH/WAIT ram_* = st_*[cur_stage]; in IDLE/FINISH all
//   ram_* = 0 (en=0, we=0). Non-active stage inputs never reach RAMs.
// - abort: highest priority outside IDLE; next edge -> IDLE, stage_start=0, busy=0, aborted pulse 1 cycle, no done.
//   abort in IDLE ignored. start while busy ignored. start and abort same cycle in IDLE: start wins.
// - rst mid-run: immediate return to reset values; no done/aborted pulse.
// - cur_iter wraps never: limit <= 2^ITER_WIDTH-1, compare done before increment overflow.
// CONFIGURATION
// - SUBSURF_SEQ_TIMEOUT_EN defined: per-stage cycle counter in WAIT; reaching TIMEOUT_CYCLES -> behave as abort
//   (aborted pulse, IDLE) and set sticky output-visible bit timeout (extra 1-bit port) cleared on next accepted start.
// - Undefined: no counter, no timeout port; WAIT waits indefinitely.
// TESTING
// - Defaults, iterations=1, each engine model busy 10 cycles -> stage_start 0,1,2 in order, each 3 cycles wide; done
//   pulse once; busy low after; cur_iter=1.
// - iterations=2, NUM_STAGES=3 -> 6 launches (0,1,2,0,1,2), done once, cur_iter=2; iterations=0 -> 3 launches.
// - Stage 1 drives ram_a[r=0]=0x2A, stage 0 drives 0x155 -> ram_a slot0 = 0x2A only while cur_stage=1; IDLE all zero.
// - abort asserted in WAIT of stage 1 -> next cycle busy=0, aborted=1 for 1 cycle, stage 2 never launched, done=0.
// - rst held 1 cycle during stage 2 LAUNCH -> all outputs at reset values next cycle; new start runs cleanly.
// - SUBSURF_SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=16, stage 0 busy stuck high -> aborted pulse, timeout=1 until next start.

Source files
------------

// File: rtl/subsurf_seq.sv
// subsurf_seq: runs NUM_STAGES engines in order ITER times and muxes the active stage onto shared RAMs.
// Define SUBSURF_SEQ_TIMEOUT_EN to add the per-stage watchdog and its sticky timeout output.
module subsurf_seq #(
  parameter int NUM_STAGES     = 3,
  parameter int NUM_RAMS       = 3,
  parameter int ADDR_WIDTH     = 11,
  parameter int START_HOLD     = 3,
  parameter int ITER_WIDTH     = 4,
  parameter int TIMEOUT_CYCLES = 65536,
  localparam int SW = NUM_STAGES > 1 ? $clog2(NUM_STAGES) : 1
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     start,
  input  logic [ITER_WIDTH-1:0]                    iterations,
  input  logic                                     abort,
  output logic [NUM_STAGES-1:0]                    stage_start,
  input  logic [NUM_STAGES-1:0]                    stage_busy,
  input  logic [NUM_STAGES*NUM_RAMS-1:0]           st_en,
  input  logic [NUM_STAGES*NUM_RAMS*ADDR_WIDTH-1:0] st_a,
  input  logic [NUM_STAGES*NUM_RAMS*4-1:0]         st_we,
  input  logic [NUM_STAGES*NUM_RAMS*32-1:0]        st_di,
  output logic [NUM_RAMS-1:0]                      ram_en,
  output logic [NUM_RAMS*ADDR_WIDTH-1:0]           ram_a,
  output logic [NUM_RAMS*4-1:0]                    ram_we,
  output logic [NUM_RAMS*32-1:0]                   ram_di,
  output logic                                     busy,
  output logic                                     done,
  output logic                                     aborted,
  output logic [SW-1:0]                            cur_stage,
`ifdef SUBSURF_SEQ_TIMEOUT_EN
  output logic                                     timeout,
`endif
  output logic [ITER_WIDTH-1:0]                    cur_iter
);
  localparam int HW = START_HOLD > 1 ? $clog2(START_HOLD) : 1;
  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, FINISH} state_e;
  state_e                state_q;
  logic [HW-1:0]         hold_q;
  logic [SW-1:0]         stage_q;
  logic [ITER_WIDTH-1:0] iter_q, limit_q;
  logic [NUM_STAGES-1:0] launch_q;
  logic                  busy_q, done_q, aborted_q;
  logic [ITER_WIDTH:0]   iter_d;
  logic                  stage_idle, expire, active;

  assign stage_idle = !stage_busy[stage_q];
  // one bit wider so the pass compare cannot wrap when limit is at its maximum
  assign iter_d = {1'b0, iter_q} + 1'b1;
  assign active = state_q == LAUNCH || state_q == WAIT;

`ifdef SUBSURF_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] wd_q;
  logic          tmo_q;
  assign expire = state_q == WAIT && !stage_idle && wd_q == TW'(TIMEOUT_CYCLES - 1);
  assign timeout = tmo_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_q  <= '0;
      tmo_q <= 1'b0;
    end else begin
      wd_q  <= state_q == WAIT ? wd_q + 1'b1 : '0;
      tmo_q <= (state_q == IDLE && start) ? 1'b0 : (tmo_q | expire);
    end
  end
`else
  logic unused_tmo;
  assign expire = 1'b0;
  assign unused_tmo = ^TIMEOUT_CYCLES;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      hold_q    <= '0;
      stage_q   <= '0;
      iter_q    <= '0;
      limit_q   <= '0;
      launch_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      if (state_q != IDLE && (abort || expire)) begin
        state_q   <= IDLE;
        launch_q  <= '0;
        busy_q    <= 1'b0;
        aborted_q <= 1'b1;
      end else begin
        case (state_q)
          IDLE: if (start) begin
            limit_q  <= iterations == '0 ? ITER_WIDTH'(1) : iterations;
            stage_q  <= '0;
            iter_q   <= '0;
            hold_q   <= '0;
            busy_q   <= 1'b1;
            launch_q <= NUM_STAGES'(1);
            state_q  <= LAUNCH;
          end
          LAUNCH: if (hold_q == HW'(START_HOLD - 1)) begin
            launch_q <= '0;
            state_q  <= WAIT;
          end else begin
            hold_q <= hold_q + 1'b1;
          end
          WAIT: if (stage_idle) begin
            hold_q <= '0;
            if (stage_q != SW'(NUM_STAGES - 1)) begin
              stage_q  <= stage_q + 1'b1;
              launch_q <= NUM_STAGES'(2) << stage_q;
              state_q  <= LAUNCH;
            end else begin
              iter_q <= iter_d[ITER_WIDTH-1:0];
              if (iter_d < {1'b0, limit_q}) begin
                stage_q  <= '0;
                launch_q <= NUM_STAGES'(1);
                state_q  <= LAUNCH;
              end else begin
                done_q  <= 1'b1;
                state_q <= FINISH;
              end
            end
          end
          default: begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  always_comb begin
    ram_en = '0;
    ram_a  = '0;
    ram_we = '0;
    ram_di = '0;
    for (int r = 0; r < NUM_RAMS; r++) begin
      ram_en[r]                         = active & st_en[int'(stage_q)*NUM_RAMS + r];
      ram_a[r*ADDR_WIDTH +: ADDR_WIDTH] = active ? st_a[(int'(stage_q)*NUM_RAMS + r)*ADDR_WIDTH +: ADDR_WIDTH] : '0;
      ram_we[r*4 +: 4]                  = active ? st_we[(int'(stage_q)*NUM_RAMS + r)*4 +: 4] : '0;
      ram_di[r*32 +: 32]                = active ? st_di[(int'(stage_q)*NUM_RAMS + r)*32 +: 32] : '0;
    end
  end

  assign stage_start = launch_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign aborted     = aborted_q;
  assign cur_stage   = stage_q;
  assign cur_iter    = iter_q;
endmodule

// File: tb/tb_subsurf_seq.sv
// tb_subsurf_seq: directed bench for subsurf_seq with engine models and a launch-order scoreboard.
module tb_subsurf_seq;
  localparam int NS = 3, NR = 3, AW = 11, IW = 4;
`ifdef SUBSURF_SEQ_TIMEOUT_EN
  localparam int TMO = 16;
`else
  localparam int TMO = 65536;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1, start = 1'b0, abort = 1'b0, stuck = 1'b0;
  logic [IW-1:0] iterations = '0;
  logic [NS-1:0] stage_start, stage_busy;
  logic [NS*NR-1:0] st_en;
  logic [NS*NR*AW-1:0] st_a;
  logic [NS*NR*4-1:0] st_we;
  logic [NS*NR*32-1:0] st_di;
  logic [NR-1:0] ram_en, e_en;
  logic [NR*AW-1:0] ram_a, e_a;
  logic [NR*4-1:0] ram_we, e_we;
  logic [NR*32-1:0] ram_di, e_di;
  logic busy, done, aborted;
  logic [1:0] cur_stage;
  logic [IW-1:0] cur_iter;
`ifdef SUBSURF_SEQ_TIMEOUT_EN
  logic timeout;
`endif
  int checks = 0, failures = 0, done_cnt = 0, ab_cnt = 0, act_stage = 0, width = 0;
  int exp_q[$];
  int eng_cnt[NS];
  logic [NS-1:0] prev_ss = '0;

  subsurf_seq #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .start(start), .iterations(iterations), .abort(abort),
    .stage_start(stage_start), .stage_busy(stage_busy),
    .st_en(st_en), .st_a(st_a), .st_we(st_we), .st_di(st_di),
    .ram_en(ram_en), .ram_a(ram_a), .ram_we(ram_we), .ram_di(ram_di),
    .busy(busy), .done(done), .aborted(aborted), .cur_stage(cur_stage),
`ifdef SUBSURF_SEQ_TIMEOUT_EN
    .timeout(timeout),
`endif
    .cur_iter(cur_iter)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic ok);
    checks++;
    if (ok !== 1'b1) begin
      failures++;
      $error("FAIL %s", tag);
    end
  endtask

  function automatic logic pat_en(int s, int r);
    return ((s * NR + r) % 4) != 3;
  endfunction
  function automatic logic [AW-1:0] pat_a(int s, int r);
    if (s == 0 && r == 0) return 11'h155;
    if (s == 1 && r == 0) return 11'h02A;
    return AW'(s * 64 + r * 7 + 1);
  endfunction
  function automatic logic [3:0] pat_we(int s, int r);
    return 4'(s * 5 + r + 1);
  endfunction
  function automatic logic [31:0] pat_di(int s, int r);
    return 32'hC0DE_0000 | 32'(s << 8) | 32'(r);
  endfunction

  always @(posedge clk)
    for (int s = 0; s < NS; s++)
      if (rst) eng_cnt[s] <= 0;
      else if (stage_start[s]) eng_cnt[s] <= 10;
      else if (eng_cnt[s] > 0) eng_cnt[s] <= eng_cnt[s] - 1;

  always_comb
    for (int s = 0; s < NS; s++) stage_busy[s] = eng_cnt[s] != 0 || (stuck && s == 0);

  always @(negedge clk) begin
    if (rst) begin
      prev_ss = '0;
      width = 0;
      act_stage = 0;
    end else begin
      if (stage_start != '0 && prev_ss == '0) begin
        width = 1;
        if (exp_q.size() == 0) chk("launch_unexpected", stage_start === 3'b000);
        else begin
          act_stage = exp_q.pop_front();
          chk("launch_stage", stage_start === 3'(1 << act_stage));
        end
      end else if (stage_start != '0) width++;
      else if (prev_ss != '0) chk("start_width", width === 3);
      prev_ss = stage_start;
      for (int r = 0; r < NR; r++) begin
        e_en[r]          = busy && !done && pat_en(act_stage, r);
        e_a[r*AW +: AW]  = (busy && !done) ? pat_a(act_stage, r) : '0;
        e_we[r*4 +: 4]   = (busy && !done) ? pat_we(act_stage, r) : '0;
        e_di[r*32 +: 32] = (busy && !done) ? pat_di(act_stage, r) : '0;
      end
      chk("ram_en", ram_en === e_en);
      chk("ram_a", ram_a === e_a);
      chk("ram_we", ram_we === e_we);
      chk("ram_di", ram_di === e_di);
    end
    if (done) done_cnt++;
    if (aborted) ab_cnt++;
  end

  task automatic kick(input logic [IW-1:0] it, input logic ab);
    @(posedge clk); #1;
    iterations = it;
    start = 1'b1;
    abort = ab;
    @(posedge clk); #1;
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic run_ok(input string tag, input logic [IW-1:0] it, input int passes, input logic ab, input logic poke);
    int d0 = done_cnt;
    int n = 0;
    for (int p = 0; p < passes; p++)
      for (int s = 0; s < NS; s++) exp_q.push_back(s);
    kick(it, ab);
    while (!done && n < 2000) begin
      @(negedge clk);
      n++;
      if (poke && n == 20) begin
        start = 1'b1;
        iterations = 4'd5;
      end else start = 1'b0;
    end
    start = 1'b0;
    chk({tag, "_done"}, done === 1'b1);
    chk({tag, "_iter"}, cur_iter === IW'(passes));
    chk({tag, "_stage"}, cur_stage === 2'd2);
    @(negedge clk);
    chk({tag, "_busy_low"}, busy === 1'b0);
    chk({tag, "_done_pulse"}, done === 1'b0);
    chk({tag, "_all_launched"}, exp_q.size() === 0);
    chk({tag, "_done_count"}, (done_cnt - d0) === 1);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    int n, a0, d0;
    for (int s = 0; s < NS; s++)
      for (int r = 0; r < NR; r++) begin
        st_en[s*NR + r]              = pat_en(s, r);
        st_a[(s*NR + r)*AW +: AW]    = pat_a(s, r);
        st_we[(s*NR + r)*4 +: 4]     = pat_we(s, r);
        st_di[(s*NR + r)*32 +: 32]   = pat_di(s, r);
      end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", busy === 1'b0);
    chk("rst_done", done === 1'b0);
    chk("rst_aborted", aborted === 1'b0);
    chk("rst_stage_start", stage_start === 3'b000);
    chk("rst_cur_stage", cur_stage === 2'd0);
    chk("rst_cur_iter", cur_iter === 4'd0);
    chk("rst_ram_en", ram_en === 3'b000);
`ifdef SUBSURF_SEQ_TIMEOUT_EN
    chk("rst_timeout", timeout === 1'b0);
`endif
    run_ok("iter1", 4'd1, 1, 1'b0, 1'b0);
    run_ok("iter2", 4'd2, 2, 1'b0, 1'b1);
    run_ok("iter0", 4'd0, 1, 1'b0, 1'b0);
    @(posedge clk); #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk);
    chk("idle_abort_ignored", aborted === 1'b0);
    chk("idle_abort_busy", busy === 1'b0);
    run_ok("start_wins", 4'd1, 1, 1'b1, 1'b0);
    exp_q.push_back(0);
    exp_q.push_back(1);
    a0 = ab_cnt;
    d0 = done_cnt;
    kick(4'd1, 1'b0);
    n = 0;
    do begin @(negedge clk); n++; end while (!(cur_stage == 2'd1 && stage_start == '0 && busy) && n < 500);
    chk("abort_wait_found", n < 500);
    chk("ram_slot0_stage1", ram_a[AW-1:0] === 11'h02A);
    @(posedge clk); #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk);
    chk("abort_busy", busy === 1'b0);
    chk("abort_pulse", aborted === 1'b1);
    chk("abort_no_done", done === 1'b0);
    @(negedge clk);
    chk("abort_pulse_end", aborted === 1'b0);
    repeat (30) @(negedge clk);
    chk("abort_count", (ab_cnt - a0) === 1);
    chk("abort_done_count", (done_cnt - d0) === 0);
    chk("abort_no_stage2", exp_q.size() === 0);
    chk("idle_ram_a", ram_a === '0);
    for (int s = 0; s < NS; s++) exp_q.push_back(s);
    a0 = ab_cnt;
    d0 = done_cnt;
    kick(4'd1, 1'b0);
    n = 0;
    do begin @(negedge clk); n++; end while (!stage_start[2] && n < 500);
    chk("rst_stage2_found", stage_start === 3'b100);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_busy", busy === 1'b0);
    chk("midrst_stage_start", stage_start === 3'b000);
    chk("midrst_cur_stage", cur_stage === 2'd0);
    chk("midrst_cur_iter", cur_iter === 4'd0);
    chk("midrst_done", done === 1'b0);
    chk("midrst_aborted", aborted === 1'b0);
    repeat (5) @(negedge clk);
    chk("midrst_no_pulses", ((ab_cnt - a0) + (done_cnt - d0)) === 0);
    chk("midrst_queue", exp_q.size() === 0);
    run_ok("post_rst", 4'd1, 1, 1'b0, 1'b0);
`ifdef SUBSURF_SEQ_TIMEOUT_EN
    stuck = 1'b1;
    exp_q.push_back(0);
    kick(4'd1, 1'b0);
    n = 0;
    while (!aborted && n < 500) begin @(negedge clk); n++; end
    chk("tmo_aborted", aborted === 1'b1);
    chk("tmo_flag", timeout === 1'b1);
    chk("tmo_busy", busy === 1'b0);
    repeat (5) @(negedge clk);
    chk("tmo_sticky", timeout === 1'b1);
    stuck = 1'b0;
    run_ok("tmo_recover", 4'd1, 1, 1'b0, 1'b0);
    chk("tmo_cleared", timeout === 1'b0);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
